// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle for ram_bus_arbiter: CPU data port, AUX master port and the RAM side.
// slave = arbiter view, master = environment (CPU/AUX/RAM) view.
interface ram_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_gnt;
  logic [DW-1:0] aux_rdata;
  logic          aux_valid;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rdata, aux_valid,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rdata, aux_valid,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU has priority, AUX is forced in
// after MAX_WAIT denied cycles and may burst up to BURST_LEN. ARB_STATS_EN adds stall/grant counters.
module ram_bus_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_bus_arbiter_if.slave      bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           aux_cnt
`endif
);

  typedef enum logic {S_CPU, S_AUX} state_e;

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);
  localparam logic [3:0] BLEN = 4'(BURST_LEN);

  state_e        state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic [3:0]    burst_q, burst_d;
  logic [DW-1:0] ardata_q;
  logic          avalid_q;
  logic          gnt, rdy;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    gnt     = 1'b0;
    case (state_q)
      S_CPU: begin
        gnt = bus.aux_req & (~bus.cpu_req | (wait_q == MAXW));
        if (gnt) begin
          state_d = S_AUX;
          burst_d = 4'd1;
          wait_d  = '0;
        end else if (bus.aux_req & bus.cpu_req) begin
          if (wait_q != MAXW) wait_d = wait_q + 4'd1;
        end else if (!bus.aux_req) begin
          wait_d = '0;
        end
      end
      S_AUX: begin
        // a full burst forces one AUX-free cycle so the CPU always gets a slot
        gnt = bus.aux_req & (burst_q != BLEN);
        if (gnt) begin
          burst_d = burst_q + 4'd1;
        end else begin
          state_d = S_CPU;
          burst_d = '0;
        end
      end
      default: state_d = S_CPU;
    endcase
    if (!reset) gnt = 1'b0;
    rdy = ~(bus.cpu_req & gnt);
  end

  assign addr_mux       = gnt ? bus.aux_addr  : bus.cpu_addr;
  assign wdata_mux      = gnt ? bus.aux_wdata : bus.cpu_wdata;
  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;
  assign bus.ram_we     = reset & (gnt ? bus.aux_we : (bus.cpu_we & bus.cpu_req & rdy));
  assign bus.aux_gnt    = gnt;
  assign bus.cpu_ready  = rdy;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.aux_rdata  = ardata_q;
  assign bus.aux_valid  = avalid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CPU;
      wait_q   <= '0;
      burst_q  <= '0;
      ardata_q <= '0;
      avalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      avalid_q <= gnt & ~bus.aux_we;
      if (gnt & ~bus.aux_we) ardata_q <= bus.ram_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_q, auxc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      auxc_q  <= '0;
    end else begin
      if (bus.cpu_req & ~rdy & (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (gnt & (auxc_q != 16'hFFFF))                 auxc_q  <= auxc_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign aux_cnt   = auxc_q;
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level arbitration model and a shadow copy of the RAM.
module tb_ram_bus_arbiter;
  localparam int AW = 8, DW = 32, MAX_WAIT = 4, BURST_LEN = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt, aux_cnt;
`endif

  ram_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .aux_cnt   (aux_cnt)
`endif
  );

  // RAM instance model: combinational read, write on clock edge; preload port for setup
  logic [DW-1:0] mem [256];
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (pl_en)            mem[pl_addr]      <= pl_data;
    else if (bus.ram_we)  mem[bus.ram_addr] <= bus.ram_wdata;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 32'h20) ? 32'h12345678 : {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // reference model state
  logic [31:0] exp_mem [256];
  bit          m_burst, m_avalid;
  int          m_grants, m_denied, m_stall, m_auxc;
  logic [31:0] m_ardata;
  bit          e_rdy, o_gnt, o_rdy, o_avalid;
  logic [31:0] o_rdata, o_ardata;

  task automatic model_reset();
    m_burst = 0; m_grants = 0; m_denied = 0;
    m_avalid = 0; m_ardata = '0; m_stall = 0; m_auxc = 0;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [31:0] cd,
                       input bit ar, input bit aw, input logic [7:0] aa, input logic [31:0] ad);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.aux_req = ar; bus.aux_we = aw; bus.aux_addr = aa; bus.aux_wdata = ad;
  endtask

  // one bus cycle: drive after the falling edge, check, then advance the model
  task automatic step(input bit cr, input bit cw, input logic [7:0] ca, input logic [31:0] cd,
                      input bit ar, input bit aw, input logic [7:0] aa, input logic [31:0] ad);
    bit eg, er, ew;
    logic [7:0] ea;
    @(negedge clk);
    drive(cr, cw, ca, cd, ar, aw, aa, ad);
    #1;
    if (!m_burst) eg = ar && (!cr || m_denied >= MAX_WAIT);
    else          eg = ar && (m_grants < BURST_LEN);
    er = !(cr && eg);
    ew = eg ? aw : (cw && cr && er);
    ea = eg ? aa : ca;
    chk("aux_gnt",   bus.aux_gnt,   eg);
    chk("cpu_ready", bus.cpu_ready, er);
    chk("ram_we",    bus.ram_we,    ew);
    chk("ram_addr",  bus.ram_addr,  ea);
    if (ew) chk("ram_wdata", bus.ram_wdata, eg ? ad : cd);
    chk("aux_valid", bus.aux_valid, m_avalid);
    if (m_avalid) chk("aux_rdata", bus.aux_rdata, m_ardata);
    if (cr && !cw && er && !eg) chk("cpu_rdata", bus.cpu_rdata, exp_mem[ca]);
    o_gnt = bus.aux_gnt; o_rdy = bus.cpu_ready; o_rdata = bus.cpu_rdata;
    o_avalid = bus.aux_valid; o_ardata = bus.aux_rdata;
    e_rdy = er;
    m_avalid = eg && !aw;
    if (m_avalid) m_ardata = exp_mem[aa];
    if (ew) exp_mem[ea] = eg ? ad : cd;
    if (cr && !er) m_stall++;
    if (eg) m_auxc++;
    if (eg) begin
      m_grants = m_burst ? m_grants + 1 : 1;
      m_burst  = 1;
      m_denied = 0;
    end else if (m_burst) begin
      m_burst = 0; m_grants = 0;
    end else if (ar && cr) begin
      m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
    end else begin
      m_denied = 0;
    end
  endtask

  initial begin
    bit hold, cr, cw, ar, aw, pg;
    logic [7:0]  ca, aa;
    logic [31:0] cd, ad;

    // reset with every request asserted
    reset = 1'b0;
    drive(1, 1, 8'h55, 32'hFFFF0000, 1, 1, 8'h66, 32'h0000FFFF);
    #1;
    chk("rst_ram_we",    bus.ram_we,    0);
    chk("rst_aux_gnt",   bus.aux_gnt,   0);
    chk("rst_cpu_ready", bus.cpu_ready, 1);
    chk("rst_aux_valid", bus.aux_valid, 0);
    chk("rst_aux_rdata", bus.aux_rdata, 0);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 8'(i); pl_data = init_word(i);
      exp_mem[i] = init_word(i);
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk("rst_hold_we", bus.ram_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();

    // CPU-only write then read
    step(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("cpu_wr_ready", o_rdy, 1);
    step(1, 0, 8'h10, 0, 0, 0, 0, 0);
    chk("cpu_rd_ready", o_rdy, 1);
    chk("cpu_rd_data",  o_rdata, 32'hDEADBEEF);

    // AUX-only read of preloaded word
    step(0, 0, 0, 0, 1, 0, 8'h20, 0);
    chk("aux_rd_gnt", o_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("aux_rd_valid", o_avalid, 1);
    chk("aux_rd_data",  o_ardata, 32'h12345678);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // continuous contention: 4 CPU, 4 AUX, one CPU slot, repeating every 9 cycles
    for (int i = 0; i < 27; i++) begin
      step(1, 0, 8'h11, 0, 1, 0, 8'h12, 0);
      pg = ((i % 9) >= 4) && ((i % 9) <= 7);
      chk("pat_gnt", o_gnt, pg);
      chk("pat_rdy", o_rdy, !pg);
    end

    // AUX drops its request after two grants; pending CPU read completes
    step(0, 0, 8'h30, 0, 1, 0, 8'h21, 0);
    step(1, 0, 8'h30, 0, 1, 0, 8'h22, 0);
    chk("drop_stall", o_rdy, 0);
    step(1, 0, 8'h30, 0, 0, 0, 8'h22, 0);
    chk("drop_gnt",  o_gnt, 0);
    chk("drop_rdy",  o_rdy, 1);
    chk("drop_data", o_rdata, init_word(8'h30));
    step(1, 0, 8'h31, 0, 1, 0, 8'h23, 0);
    chk("drop_cpu_wins", o_gnt, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic; a stalled CPU holds its request unchanged
    hold = 0; cr = 0; cw = 0; ca = '0; cd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = 1'($urandom_range(0, 1));
        ca = 8'h40 + 8'($urandom_range(0, 15));
        cd = $urandom;
      end
      ar = ($urandom_range(0, 2) != 0);
      aw = 1'($urandom_range(0, 1));
      aa = 8'h40 + 8'($urandom_range(0, 15));
      ad = $urandom;
      step(cr, cw, ca, cd, ar, aw, aa, ad);
      hold = cr && !e_rdy;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_STATS_EN
    chk("stall_cnt", stall_cnt, 64'(m_stall));
    chk("aux_cnt",   aux_cnt,   64'(m_auxc));
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // reset asserted during an AUX write burst with two grants done
    step(0, 0, 0, 0, 1, 1, 8'h80, 32'hAAAA0001);
    step(0, 0, 0, 0, 1, 1, 8'h81, 32'hAAAA0002);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 8'h82, 32'hAAAA0003);
    #1;
    chk("burst3_we", bus.ram_we, 1);
    reset = 1'b0;
    #1;
    chk("midrst_we",  bus.ram_we,    0);
    chk("midrst_gnt", bus.aux_gnt,   0);
    chk("midrst_rdy", bus.cpu_ready, 1);
    @(posedge clk);
    #1;
    chk("midrst_nowrite", mem[8'h82], init_word(8'h82));
    chk("burst_wr0",      mem[8'h80], 32'hAAAA0001);
    chk("burst_wr1",      mem[8'h81], 32'hAAAA0002);
`ifdef ARB_STATS_EN
    chk("midrst_stall_cnt", stall_cnt, 0);
    chk("midrst_aux_cnt",   aux_cnt,   0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    exp_mem[8'h80] = 32'hAAAA0001;
    exp_mem[8'h81] = 32'hAAAA0002;
    step(1, 0, 8'h82, 0, 0, 0, 0, 0);
    chk("post_rst_rd", o_rdata, init_word(8'h82));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
